// File: rtl/regfile_wb_seq.sv
// regfile_wb_seq
//   Register file plus write-back sequencer for a multi-cycle datapath.
//   One operation at a time: its register indices and control bits are
//   latched on the accepting edge. The operand/address registers are then
//   presented combinationally. The result is written back from either the
//   external ALU (one EXEC cycle) or external memory (valid handshake with
//   a timeout). The block also holds the processor flag register.
//
// Ports
//   CLK          clock, rising edge
//   CLR          synchronous reset, active-low
//   start        issue an operation (accepted only while idle)
//   wr_en        operation writes register ld_reg
//   sel_mem      0: write back alu_result, 1: write back ext_din
//   flag_we      operation updates stored_flags from alu_flags
//   rd_a/rd_b    operand register indices
//   rd_m         memory address register index
//   ld_reg       destination register index
//   alu_result   ALU result, sampled at the end of EXEC
//   alu_flags    ALU flags, sampled at the end of EXEC
//   ext_din      memory read data
//   ext_valid    ext_din valid this cycle (only looked at in WAIT_MEM)
//   A/RegB/addr1 contents of the latched rd_a/rd_b/rd_m registers
//   stored_flags flag register
//   busy         sequencer not idle
//   done         one-cycle completion pulse
//   err          last operation timed out waiting for memory
module regfile_wb_seq #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 16,
  parameter int AW      = 4,
  parameter int NFLAGS  = 5,
  parameter int TIMEOUT = 255,
  parameter int ZERO_R0 = 0
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic              wr_en,
  input  logic              sel_mem,
  input  logic              flag_we,
  input  logic [AW-1:0]     rd_a,
  input  logic [AW-1:0]     rd_b,
  input  logic [AW-1:0]     rd_m,
  input  logic [AW-1:0]     ld_reg,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic [WIDTH-1:0]  ext_din,
  input  logic              ext_valid,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  RegB,
  output logic [WIDTH-1:0]  addr1,
  output logic [NFLAGS-1:0] stored_flags,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_WAIT_MEM = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              wr_en_q, wr_en_d;
  logic              sel_mem_q, sel_mem_d;
  logic              flag_we_q, flag_we_d;
  logic [AW-1:0]     rd_a_q, rd_a_d;
  logic [AW-1:0]     rd_b_q, rd_b_d;
  logic [AW-1:0]     rd_m_q, rd_m_d;
  logic [AW-1:0]     ld_reg_q, ld_reg_d;

  logic [WIDTH-1:0]  reg_q [NREGS];
  logic              wr_fire;
  logic [WIDTH-1:0]  wr_data;
  logic [NREGS-1:0]  we_vec;

  // Sequencer: next state, write-back request and flag update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    flags_d   = flags_q;
    wr_en_d   = wr_en_q;
    sel_mem_d = sel_mem_q;
    flag_we_d = flag_we_q;
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    rd_m_d    = rd_m_q;
    ld_reg_d  = ld_reg_q;
    wr_fire   = 1'b0;
    wr_data   = alu_result;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_en_d   = wr_en;
          sel_mem_d = sel_mem;
          flag_we_d = flag_we;
          rd_a_d    = rd_a;
          rd_b_d    = rd_b;
          rd_m_d    = rd_m;
          ld_reg_d  = ld_reg;
          err_d     = 1'b0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (flag_we_q) flags_d = alu_flags;
        if (!sel_mem_q) begin
          wr_fire = wr_en_q;
          wr_data = alu_result;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        // valid is checked first so it wins over a same-edge timeout
        if (ext_valid) begin
          wr_fire = wr_en_q;
          wr_data = ext_din;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      flags_q   <= '0;
      wr_en_q   <= 1'b0;
      sel_mem_q <= 1'b0;
      flag_we_q <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      rd_m_q    <= '0;
      ld_reg_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      flags_q   <= flags_d;
      wr_en_q   <= wr_en_d;
      sel_mem_q <= sel_mem_d;
      flag_we_q <= flag_we_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      rd_m_q    <= rd_m_d;
      ld_reg_q  <= ld_reg_d;
    end
  end

  // Write decode: indices at or beyond NREGS match no entry, so such
  // writes are dropped; r0 is excluded when it is hard-wired to zero.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
    assign we_vec[gi] = wr_fire && (ld_reg_q == AW'(gi)) &&
                        !((ZERO_R0 != 0) && (gi == 0));
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!CLR) begin
        reg_q[i] <= '0;
      end else if (we_vec[i]) begin
        reg_q[i] <= wr_data;
      end
    end
  end

  // Read ports: no bypass, out-of-range indices read as zero
  always_comb begin
    A     = '0;
    RegB  = '0;
    addr1 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!((ZERO_R0 != 0) && (i == 0))) begin
        if (rd_a_q == AW'(i)) A     = reg_q[i];
        if (rd_b_q == AW'(i)) RegB  = reg_q[i];
        if (rd_m_q == AW'(i)) addr1 = reg_q[i];
      end
    end
  end

  assign stored_flags = flags_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;

endmodule

// File: tb/tb_regfile_wb_seq.sv
module tb_regfile_wb_seq;

  localparam int W  = 16;
  localparam int NR = 12;
  localparam int AW = 4;
  localparam int NF = 5;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          CLR, start, wr_en, sel_mem, flag_we, ext_valid;
  logic [AW-1:0] rd_a, rd_b, rd_m, ld_reg;
  logic [W-1:0]  alu_result, ext_din, A, RegB, addr1;
  logic [NF-1:0] alu_flags, stored_flags;
  logic          busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural register contents, flags and error bit
  logic [W-1:0]  mregs [16];
  logic [NF-1:0] mflags;
  logic          merr;

  always #5 CLK = ~CLK;

  regfile_wb_seq #(
    .WIDTH(W), .NREGS(NR), .AW(AW), .NFLAGS(NF), .TIMEOUT(TO), .ZERO_R0(0)
  ) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .wr_en(wr_en), .sel_mem(sel_mem),
    .flag_we(flag_we), .rd_a(rd_a), .rd_b(rd_b), .rd_m(rd_m), .ld_reg(ld_reg),
    .alu_result(alu_result), .alu_flags(alu_flags), .ext_din(ext_din),
    .ext_valid(ext_valid), .A(A), .RegB(RegB), .addr1(addr1),
    .stored_flags(stored_flags), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [W-1:0] mread(input logic [AW-1:0] i);
    if (int'(i) < NR) return mregs[i];
    return '0;
  endfunction

  function automatic void mclear();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = '0;
    merr   = 1'b0;
  endfunction

  // Issues one operation from an idle negedge and follows it to completion.
  // vdly: index of the WAIT_MEM cycle in which ext_valid is raised
  // (>= TO means never, i.e. a timeout).
  task automatic run_op(input logic mem, input logic we, input logic fwe,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic [AW-1:0] rm, input logic [AW-1:0] ld,
                        input logic [W-1:0] res, input logic [NF-1:0] fl,
                        input logic [W-1:0] din, input int vdly, input string tag);
    int            exp_n, edges;
    bit            got;
    logic [W-1:0]  pa, pb, pm;
    pa = mread(ra);
    pb = mread(rb);
    pm = mread(rm);
    if (fwe) mflags = fl;
    if (!mem) begin
      exp_n = 1;
      merr  = 1'b0;
      if (we && int'(ld) < NR) mregs[ld] = res;
    end else if (vdly < TO) begin
      exp_n = 2 + vdly;
      merr  = 1'b0;
      if (we && int'(ld) < NR) mregs[ld] = din;
    end else begin
      exp_n = 1 + TO;
      merr  = 1'b1;
    end

    start = 1'b1; wr_en = we; sel_mem = mem; flag_we = fwe;
    rd_a = ra; rd_b = rb; rd_m = rm; ld_reg = ld;
    alu_result = res; alu_flags = fl; ext_valid = 1'b0; ext_din = W'($urandom);
    @(posedge CLK);
    edges = 0;
    got   = 0;
    while (!got && edges < 40) begin
      @(negedge CLK);
      if (done) begin
        got = 1;
      end else begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s busy_during_op: got %0b want 1 (cycle %0d)", tag, busy, edges);
        end
        if (edges == 0) begin
          n_cmp++;
          if ({A, RegB, addr1} !== {pa, pb, pm}) begin
            n_bad++;
            $display("FAIL %s operands_exec: got %h/%h/%h want %h/%h/%h", tag, A, RegB, addr1, pa, pb, pm);
          end
          n_cmp++;
          if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s err_cleared_on_start: got %0b want 0", tag, err);
          end
        end
        // Scramble everything the DUT should already have latched
        start   = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        sel_mem = 1'($urandom_range(0, 1));
        flag_we = 1'($urandom_range(0, 1));
        rd_a    = AW'($urandom);
        rd_b    = AW'($urandom);
        rd_m    = AW'($urandom);
        ld_reg  = AW'($urandom);
        if (edges >= 1) begin
          alu_result = W'($urandom);
          alu_flags  = NF'($urandom);
        end
        if (mem && edges >= 1) begin
          ext_valid = (edges - 1 == vdly);
          ext_din   = ext_valid ? din : W'($urandom);
        end else begin
          ext_valid = 1'($urandom_range(0, 1));
          ext_din   = W'($urandom);
        end
        @(posedge CLK);
        edges++;
      end
    end

    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s done_wait: got no done within 40 cycles want done after %0d", tag, exp_n);
    end else begin
      if (edges !== exp_n) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", tag, edges, exp_n);
      end
      n_cmp++;
      if ({A, RegB, addr1} !== {mread(ra), mread(rb), mread(rm)}) begin
        n_bad++;
        $display("FAIL %s operands_done: got %h/%h/%h want %h/%h/%h", tag, A, RegB, addr1,
                 mread(ra), mread(rb), mread(rm));
      end
      n_cmp++;
      if (stored_flags !== mflags) begin
        n_bad++;
        $display("FAIL %s flags: got %b want %b", tag, stored_flags, mflags);
      end
      n_cmp++;
      if ({busy, err} !== {1'b1, merr}) begin
        n_bad++;
        $display("FAIL %s busy_err_at_done: got %0b%0b want 1%0b", tag, busy, err, merr);
      end
    end
    start     = 1'b0;
    ext_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({done, busy, err} !== {2'b00, merr}) begin
      n_bad++;
      $display("FAIL %s idle_after: got done=%0b busy=%0b err=%0b want 0 0 %0b", tag, done, busy, err, merr);
    end
    $display("op %-8s mem=%0b we=%0b fwe=%0b ld=%0d ra=%0d A=%h flags=%b err=%0b lat=%0d",
             tag, mem, we, fwe, ld, ra, A, stored_flags, err, edges);
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++;
    if ({busy, done, err, stored_flags} !== '0) begin
      n_bad++;
      $display("FAIL %s reset_state: got busy=%0b done=%0b err=%0b flags=%b want all 0",
               tag, busy, done, err, stored_flags);
    end
    n_cmp++;
    if ({A, RegB, addr1} !== '0) begin
      n_bad++;
      $display("FAIL %s reset_reads: got %h/%h/%h want 0/0/0", tag, A, RegB, addr1);
    end
  endtask

  task automatic probe_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, 1'b0, 1'b0, AW'(i), AW'(i + 1), AW'(i + 2), AW'(0),
             W'($urandom), NF'($urandom), W'($urandom), 0, tag);
    end
  endtask

  task automatic test_reset();
    CLR = 1'b0; start = 0; wr_en = 0; sel_mem = 0; flag_we = 0; ext_valid = 0;
    rd_a = 0; rd_b = 0; rd_m = 0; ld_reg = 0; alu_result = 0; alu_flags = 0; ext_din = 0;
    mclear();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_cleared("reset_hold");
    CLR = 1'b1;
    @(negedge CLK);
    check_cleared("reset_rel");
  endtask

  task automatic test_alu_op();
    run_op(1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd3, 4'd3, 16'hBEEF, 5'b0, 16'h0, 0, "alu");
    run_op(1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 4'd1, 4'd9, 16'h1111, 5'b0, 16'h0, 0, "alu_rd");
  endtask

  task automatic test_mem_op();
    run_op(1'b1, 1'b1, 1'b0, 4'd5, 4'd3, 4'd0, 4'd5, 16'hDEAD, 5'b0, 16'h1234, 4, "mem");
    run_op(1'b1, 1'b1, 1'b0, 4'd6, 4'd5, 4'd0, 4'd6, 16'h0, 5'b0, 16'hA5A5, 0, "mem_v0");
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b1, 1'b0, 4'd5, 4'd6, 4'd3, 4'd5, 16'h0, 5'b0, 16'h7777, 100, "timeout");
    run_op(1'b1, 1'b1, 1'b0, 4'd7, 4'd5, 4'd6, 4'd7, 16'h0, 5'b0, 16'h4321, TO - 1, "tie_vld");
  endtask

  task automatic test_flags_guards();
    run_op(1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 4'd7, 4'd3, 16'hFFFF, 5'b10101, 16'h0, 0, "flags");
    run_op(1'b1, 1'b0, 1'b1, 4'd3, 4'd5, 4'd7, 4'd5, 16'h0, 5'b01010, 16'h9999, 2, "flg_mem");
    for (int i = NR; i < 16; i++) begin
      run_op(1'b0, 1'b1, 1'b0, AW'(i), AW'(i), AW'(i), AW'(i), 16'hCAFE, 5'b0, 16'h0, 0, "oob_wr");
    end
  endtask

  task automatic test_random();
    logic m;
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom_range(0, 1));
      run_op(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
             W'($urandom), NF'($urandom), W'($urandom), $urandom_range(0, TO + 2), "rand");
    end
  endtask

  task automatic test_reset_after_writes();
    for (int i = 0; i < NR; i++) begin
      run_op(1'b0, 1'b1, 1'b1, AW'(i), 4'd0, 4'd0, AW'(i), W'($urandom) | 16'h1,
             NF'($urandom) | 5'h1, 16'h0, 0, "fill");
    end
    CLR = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    mclear();
    check_cleared("rst_wr");
    probe_all("probe");
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 5'b11111, 16'h0, 0, "pre_flag");
    start = 1'b1; sel_mem = 1'b1; wr_en = 1'b1; flag_we = 1'b0; ld_reg = 4'd7;
    rd_a = 4'd7; rd_b = 4'd0; rd_m = 4'd0;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    mclear();
    ext_valid = 1'b1;
    ext_din   = 16'h5A5A;
    check_cleared("rst_mid");
    saw_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (done || busy) saw_done = 1;
    end
    ext_valid = 1'b0;
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL rst_mid no_activity: got done/busy high after reset want idle");
    end
    run_op(1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 4'd7, 4'd0, 16'h0, 5'b0, 16'h0, 0, "rst_prb");
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_mem_op();
    test_timeout();
    test_flags_guards();
    test_random();
    test_reset_after_writes();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
